score_ctrl: RTL and testbench
=============================

Name: score_ctrl

Overview:
Game-level score controller sitting between the ball/collision logic and the seven-segment score decoder. It counts points for both players, freezes play for a fixed hold time after each point, and detects the winning score. At game over it blinks the winner's digit. It drives the decoder's p1_score/p2_score inputs and gates ball motion through ball_en.

Parameters:
WIN_SCORE, 9, score that ends the game (legal range 1..9).
HOLD_MS, 1000, number of clk_1ms ticks play stays frozen after a point (legal range 1..1023).
BLINK_MS, 250, number of clk_1ms ticks per blink half-period in game over (legal range 1..1023).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset.
clk_1ms  in  1  1 ms tick; single-cycle pulse in the clk domain, used as a count enable only.
start  in  1  single-cycle start/restart request (debounced upstream).
p1_point  in  1  single-cycle pulse: player 1 scored.
p2_point  in  1  single-cycle pulse: player 2 scored.
disp_p1  out  4  digit value to the decoder's p1_score; 4'hF means blank.
disp_p2  out  4  digit value to the decoder's p2_score; 4'hF means blank.
ball_en  out  1  high only while play is live.
game_over  out  1  high in the OVER state.
winner  out  1  0 = player 1 won, 1 = player 2 won; valid while game_over is high.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=SERVE; scores=0; ms counter=0; blink phase=visible.
  - Outputs: disp_p1=0, disp_p2=0, ball_en=0, game_over=0, winner=0.
  - Reset overrides every other input, including mid-HOLD and mid-OVER.
- State is registered and all outputs are registered: one-cycle latency from input to output.
- SERVE:
  - ball_en=0; points ignored.
  - start=1 -> PLAY.
- PLAY:
  - ball_en=1.
  - Exactly one of p1_point/p2_point high -> that score increments by 1.
    - If the new score equals WIN_SCORE -> OVER, with winner set to the scorer.
    - Otherwise -> HOLD, with ms counter cleared.
  - Both points high in the same cycle -> ignored; stay in PLAY; no score change.
  - start is ignored.
- HOLD:
  - ball_en=0; points ignored.
  - The counter increments on each clk_1ms pulse. When it reaches HOLD_MS-1 and a tick arrives -> PLAY.
  - HOLD therefore lasts exactly HOLD_MS ticks.
  - start is ignored.
- OVER:
  - game_over=1; ball_en=0; points ignored.
  - The winner's digit alternates between its score and 4'hF every BLINK_MS ticks, starting visible on entry. The loser's digit is steady.
  - start=1 -> clear both scores, blink phase=visible, game_over=0 -> SERVE.
- Score width is 4 bits. Scores never exceed WIN_SCORE, so there is no wrap-around. Points are ignored outside PLAY.
- The ms counter is 10 bits. It is cleared on every state entry, so blink and hold timing start from 0.
- clk_1ms coinciding with a state transition: the transition wins and the tick is not counted.
- Blanking only ever applies to the winner's digit in OVER. In all other states both displays show the live scores.

Decomposition:
- Shared package: state encoding (SERVE, PLAY, HOLD, OVER), the BLANK_DIGIT=4'hF constant, and the ms counter width.
- Optional sub-module ms_timer: a loadable 10-bit tick counter with clear, enable and terminal-count output. It is reused for HOLD and for the blink period.
- Everything else stays in score_ctrl.

Test Plan:
1. Release reset, pulse start -> next cycle ball_en=1, disp_p1=0, disp_p2=0, game_over=0.
2. In PLAY, pulse p1_point -> disp_p1=1, ball_en=0. After exactly HOLD_MS (1000) clk_1ms ticks ball_en=1. Points pulsed during HOLD leave scores unchanged.
3. In PLAY, pulse p1_point and p2_point in the same cycle -> scores unchanged, ball_en stays 1.
4. Drive p2 from 8 to 9 with WIN_SCORE=9 -> game_over=1, winner=1. disp_p2 alternates 9/4'hF every 250 ticks; disp_p1 stays steady.
5. In OVER, pulse start -> scores 0/0, game_over=0, state SERVE (ball_en=0 until the next start).
6. Assert reset mid-HOLD and again mid-OVER -> next cycle all outputs at reset values, and the blink and hold counters restart from 0.

Source files
------------

// File: rtl/score_ctrl_pkg.sv
//==============================================================================
// score_ctrl_pkg : shared state encoding and constants for the score controller
// Rev 1.0
//==============================================================================
`default_nettype none

package score_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  localparam int         MS_W        = 10;

endpackage

`default_nettype wire

// File: rtl/score_ctrl_if.sv
//==============================================================================
// score_ctrl_if : tick/event inputs and display/status outputs of score_ctrl
// Rev 1.0
//==============================================================================
`default_nettype none

interface score_ctrl_if;

  logic       clk_1ms;
  logic       start;
  logic       p1_point;
  logic       p2_point;
  logic [3:0] disp_p1;
  logic [3:0] disp_p2;
  logic       ball_en;
  logic       game_over;
  logic       winner;

  modport master (
    output clk_1ms, start, p1_point, p2_point,
    input  disp_p1, disp_p2, ball_en, game_over, winner
  );

  modport slave (
    input  clk_1ms, start, p1_point, p2_point,
    output disp_p1, disp_p2, ball_en, game_over, winner
  );

endinterface

`default_nettype wire

// File: rtl/score_ctrl_ms_timer.sv
//==============================================================================
// score_ctrl_ms_timer : 1 ms tick counter with clear, enable and terminal count
// Rev 1.0
//==============================================================================
`default_nettype none

module score_ctrl_ms_timer
  import score_ctrl_pkg::*;
(
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            i_clr,
  input  wire logic            i_en,
  input  wire logic [MS_W-1:0] i_last,
  output logic                 o_tc
);

  logic [MS_W-1:0] r_cnt;

  assign o_tc = (r_cnt == i_last);

  // A tick on the terminal count wraps to zero so the next period starts clean.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/score_ctrl.sv
//==============================================================================
// score_ctrl : two-player score keeping, post-point hold and game-over blink
// Rev 1.0
//==============================================================================
`default_nettype none

module score_ctrl
  import score_ctrl_pkg::*;
#(
  parameter int WIN_SCORE = 9,
  parameter int HOLD_MS   = 1000,
  parameter int BLINK_MS  = 250
) (
  input  wire logic   clk,
  input  wire logic   reset,
  score_ctrl_if.slave bus
);

  localparam logic [3:0]      c_win        = 4'(WIN_SCORE);
  localparam logic [MS_W-1:0] c_hold_last  = MS_W'(HOLD_MS - 1);
  localparam logic [MS_W-1:0] c_blink_last = MS_W'(BLINK_MS - 1);

  state_e          r_state, w_state_nx;
  logic [3:0]      r_p1, r_p2, w_p1_nx, w_p2_nx;
  logic [3:0]      w_p1_inc, w_p2_inc;
  logic            r_winner, w_winner_nx;
  logic            r_blank, w_blank_nx;
  logic [3:0]      r_disp_p1, r_disp_p2, w_disp_p1_nx, w_disp_p2_nx;
  logic            r_ball_en, r_game_over;
  logic            w_tmr_en, w_tmr_clr, w_tmr_tc, w_tick_tc;
  logic [MS_W-1:0] w_tmr_last;

  assign w_p1_inc   = r_p1 + 4'd1;
  assign w_p2_inc   = r_p2 + 4'd1;
  assign w_tmr_en   = bus.clk_1ms && (r_state == ST_HOLD || r_state == ST_OVER);
  assign w_tmr_clr  = (w_state_nx != r_state);
  assign w_tmr_last = (r_state == ST_HOLD) ? c_hold_last : c_blink_last;
  assign w_tick_tc  = bus.clk_1ms && w_tmr_tc;

  score_ctrl_ms_timer u_ms_timer (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_tmr_clr),
    .i_en   (w_tmr_en),
    .i_last (w_tmr_last),
    .o_tc   (w_tmr_tc)
  );

  always_comb begin
    w_state_nx  = r_state;
    w_p1_nx     = r_p1;
    w_p2_nx     = r_p2;
    w_winner_nx = r_winner;
    w_blank_nx  = r_blank;
    unique case (r_state)
      ST_SERVE: begin
        if (bus.start) w_state_nx = ST_PLAY;
      end
      ST_PLAY: begin
        if (bus.p1_point && !bus.p2_point) begin
          w_p1_nx = w_p1_inc;
          if (w_p1_inc == c_win) begin
            w_state_nx  = ST_OVER;
            w_winner_nx = 1'b0;
            w_blank_nx  = 1'b0;
          end else begin
            w_state_nx = ST_HOLD;
          end
        end else if (bus.p2_point && !bus.p1_point) begin
          w_p2_nx = w_p2_inc;
          if (w_p2_inc == c_win) begin
            w_state_nx  = ST_OVER;
            w_winner_nx = 1'b1;
            w_blank_nx  = 1'b0;
          end else begin
            w_state_nx = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (w_tick_tc) w_state_nx = ST_PLAY;
      end
      ST_OVER: begin
        // Restart takes priority over a coincident blink tick.
        if (bus.start) begin
          w_state_nx = ST_SERVE;
          w_p1_nx    = 4'd0;
          w_p2_nx    = 4'd0;
          w_blank_nx = 1'b0;
        end else if (w_tick_tc) begin
          w_blank_nx = ~r_blank;
        end
      end
      default: w_state_nx = ST_SERVE;
    endcase
  end

  assign w_disp_p1_nx = (w_state_nx == ST_OVER && w_blank_nx && !w_winner_nx) ? BLANK_DIGIT : w_p1_nx;
  assign w_disp_p2_nx = (w_state_nx == ST_OVER && w_blank_nx &&  w_winner_nx) ? BLANK_DIGIT : w_p2_nx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_SERVE;
      r_p1        <= 4'd0;
      r_p2        <= 4'd0;
      r_winner    <= 1'b0;
      r_blank     <= 1'b0;
      r_disp_p1   <= 4'd0;
      r_disp_p2   <= 4'd0;
      r_ball_en   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_p1        <= w_p1_nx;
      r_p2        <= w_p2_nx;
      r_winner    <= w_winner_nx;
      r_blank     <= w_blank_nx;
      r_disp_p1   <= w_disp_p1_nx;
      r_disp_p2   <= w_disp_p2_nx;
      r_ball_en   <= (w_state_nx == ST_PLAY);
      r_game_over <= (w_state_nx == ST_OVER);
    end
  end

  assign bus.disp_p1   = r_disp_p1;
  assign bus.disp_p2   = r_disp_p2;
  assign bus.ball_en   = r_ball_en;
  assign bus.game_over = r_game_over;
  assign bus.winner    = r_winner;

endmodule

`default_nettype wire

// File: tb/tb_score_ctrl.sv
//==============================================================================
// tb_score_ctrl : randomized directed sequence checked against a game-level model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_score_ctrl;

  localparam int WIN_SCORE = 9;
  localparam int HOLD_MS   = 1000;
  localparam int BLINK_MS  = 250;

  logic clk = 1'b0;
  logic reset;
  int   n_asserts = 0;
  int   n_fails   = 0;

  // Model of the game: phase flags plus remaining hold ticks and ticks spent in game over.
  bit m_serving, m_live, m_holding, m_over, m_winner;
  int m_p1, m_p2, m_hold_left, m_over_ticks;

  score_ctrl_if bus ();

  score_ctrl #(
    .WIN_SCORE (WIN_SCORE),
    .HOLD_MS   (HOLD_MS),
    .BLINK_MS  (BLINK_MS)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic bit rbit(input int n);
    return ($urandom_range(n - 1) == 0);
  endfunction

  function automatic bit rtick();
    return ($urandom_range(7) != 0);
  endfunction

  task automatic model_step(input bit rstn, input bit tick, input bit st, input bit a, input bit b);
    if (!rstn) begin
      m_serving = 1; m_live = 0; m_holding = 0; m_over = 0; m_winner = 0;
      m_p1 = 0; m_p2 = 0; m_hold_left = 0; m_over_ticks = 0;
    end else if (m_serving) begin
      if (st) begin m_serving = 0; m_live = 1; end
    end else if (m_live) begin
      if (a != b) begin
        if (a) m_p1++; else m_p2++;
        m_live = 0;
        if ((a ? m_p1 : m_p2) == WIN_SCORE) begin
          m_over = 1; m_winner = b; m_over_ticks = 0;
        end else begin
          m_holding = 1; m_hold_left = HOLD_MS;
        end
      end
    end else if (m_holding) begin
      if (tick) begin
        m_hold_left--;
        if (m_hold_left == 0) begin m_holding = 0; m_live = 1; end
      end
    end else if (m_over) begin
      if (st) begin
        m_over = 0; m_serving = 1; m_p1 = 0; m_p2 = 0; m_over_ticks = 0;
      end else if (tick) begin
        m_over_ticks++;
      end
    end
  endtask

  function automatic logic [3:0] exp_digit(input int score, input bit is_winner);
    bit visible;
    visible = ((m_over_ticks / BLINK_MS) % 2) == 0;
    if (m_over && is_winner && !visible) return 4'hF;
    return 4'(score);
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("disp_p1",   bus.disp_p1,             exp_digit(m_p1, m_over && !m_winner));
    chk("disp_p2",   bus.disp_p2,             exp_digit(m_p2, m_over &&  m_winner));
    chk("ball_en",   {3'b0, bus.ball_en},     {3'b0, m_live});
    chk("game_over", {3'b0, bus.game_over},   {3'b0, m_over});
    chk("winner",    {3'b0, bus.winner},      {3'b0, m_winner});
  endtask

  task automatic step(input bit rstn, input bit tick, input bit st, input bit a, input bit b);
    @(negedge clk);
    reset        = rstn;
    bus.clk_1ms  = tick;
    bus.start    = st;
    bus.p1_point = a;
    bus.p2_point = b;
    @(posedge clk);
    model_step(rstn, tick, st, a, b);
    #1;
    check_all();
  endtask

  task automatic run_until_live(input int budget);
    for (int i = 0; i < budget && !m_live; i++)
      step(1, rtick(), rbit(4), rbit(4), rbit(4));
    chk("hold_to_play", {3'b0, bus.ball_en}, 4'h1);
  endtask

  task automatic score_point(input bit who);
    step(1, rtick(), rbit(4), who == 1'b0, who == 1'b1);
    if (!m_over) run_until_live(4000);
  endtask

  initial begin
    reset        = 1'b0;
    bus.clk_1ms  = 1'b0;
    bus.start    = 1'b0;
    bus.p1_point = 1'b0;
    bus.p2_point = 1'b0;

    // Reset dominates active inputs.
    repeat (3) step(0, 1, 1, 1, 1);
    chk("reset_disp_p1", bus.disp_p1, 4'h0);
    chk("reset_ball_en", {3'b0, bus.ball_en}, 4'h0);

    // Points in SERVE are ignored; start enters PLAY next cycle.
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0);
    chk("serve_to_play", {3'b0, bus.ball_en}, 4'h1);
    step(1, 0, 0, 0, 0);

    score_point(0);
    chk("p1_after_hold", bus.disp_p1, 4'h1);

    // Simultaneous points are ignored in PLAY.
    step(1, 0, 1, 1, 1);
    step(1, 1, 0, 1, 1);
    chk("both_points", {3'b0, bus.ball_en}, 4'h1);

    // Game won by player 2.
    for (int g = 0; g < 40 && !m_over; g++) begin
      if (rbit(3)) step(1, rtick(), rbit(2), 1, 1);
      score_point((m_p1 < 3 && rbit(2)) ? 1'b0 : 1'b1);
    end
    chk("over_p2",   {3'b0, bus.game_over}, 4'h1);
    chk("winner_p2", {3'b0, bus.winner},    4'h1);
    chk("p2_nine",   bus.disp_p2,           4'h9);

    for (int i = 0; i < 900; i++) step(1, rtick(), 0, rbit(3), rbit(3));

    // Restart with a coincident tick.
    step(1, 1, 1, 0, 0);
    chk("restart_p2",   bus.disp_p2,             4'h0);
    chk("restart_over", {3'b0, bus.game_over},   4'h0);
    step(1, 1, 0, 1, 0);

    // Reset in the middle of HOLD, then a full hold from zero.
    step(1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0);
    for (int i = 0; i < 300; i++) step(1, rtick(), rbit(4), rbit(4), rbit(4));
    step(0, 1, 1, 1, 0);
    chk("hold_reset_p1", bus.disp_p1, 4'h0);
    step(1, 0, 1, 0, 0);
    score_point(1);

    // Game won by player 1, then reset in the middle of OVER.
    for (int g = 0; g < 40 && !m_over; g++)
      score_point((m_p2 < 2 && rbit(3)) ? 1'b1 : 1'b0);
    chk("winner_p1", {3'b0, bus.winner}, 4'h0);
    for (int i = 0; i < 400; i++) step(1, rtick(), 0, rbit(3), rbit(3));
    step(0, 1, 0, 0, 0);
    chk("over_reset_go", {3'b0, bus.game_over}, 4'h0);
    chk("over_reset_p1", bus.disp_p1, 4'h0);
    step(1, 1, 1, 0, 0);
    repeat (5) step(1, rtick(), 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
